// File: rtl/ble_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ble_cmd_rx
// Brief    : 8N1 serial byte receiver for the BLE command link, with a ready
//            flag, a frame-error pulse and an overrun pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ble_cmd_rx #(
    parameter int BAUD_CNT = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err,
    output logic       ovr
);

    // The counter runs down to zero and reloads on expiry, so a load of N spans
    // N+1 clocks; whole-bit reloads use BAUD_CNT-1 to keep the bit period exact.
    localparam logic [11:0] c_half_load = 12'(BAUD_CNT / 2);
    localparam logic [11:0] c_bit_load  = 12'(BAUD_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [11:0] r_cnt;
    logic [11:0] w_cnt_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_rdy_nxt;
    logic        w_ferr_nxt;
    logic        w_ovr_nxt;
    logic        w_expire;

    assign w_expire = (r_cnt == 12'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            r_sync1   <= RX;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            rx_data   <= w_data_nxt;
            rdy       <= w_rdy_nxt;
            frame_err <= w_ferr_nxt;
            ovr       <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = rx_data;
        w_rdy_nxt   = rdy & ~clr_rdy;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_prev && !r_sync2) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = c_half_load;
                end
            end
            START: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - 12'd1;
                end else if (r_sync2) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = c_bit_load;
                    w_bit_nxt   = '0;
                end
            end
            DATA: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - 12'd1;
                end else begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = c_bit_load;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - 12'd1;
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    // A good stop bit wins over a coincident clr_rdy.
                    if (r_sync2) begin
                        w_data_nxt = r_shift;
                        w_rdy_nxt  = 1'b1;
                        w_ovr_nxt  = rdy;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
